riscv_test_monitor: RTL and testbench

- Synthesizable, parametrised successor to the simulation-only riscv-tests pass/fail checker.
- Snoops the register-file write ports of the RV64 core and keeps shadow copies of the test-number, done and pass registers.
- Reports pass, fail or timeout exactly once, with sticky status, a cycle counter and a retired-instruction counter.
- Sits beside the core in soc; drives the bench's $display logic and, on FPGA, LEDs or a UART status byte.

---
 rtl/riscv_test_monitor.sv | 157 +++++++++++++++
 tb/tb_riscv_test_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: snoops register-file write ports, shadows the riscv-tests
// test-number and pass registers, and reports pass/fail/timeout once with sticky status.
module riscv_test_monitor #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned NPORTS         = 1,
    parameter int unsigned NUM_REG        = 3,
    parameter int unsigned DONE_REG       = 26,
    parameter int unsigned PASS_REG       = 27,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic [NPORTS-1:0]      rf_we_i,
    input  logic [5*NPORTS-1:0]    rf_waddr_i,
    input  logic [XLEN*NPORTS-1:0] rf_wdata_i,
    input  logic [NPORTS-1:0]      retire_i,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic                   timeout_o,
    output logic [XLEN-1:0]        testnum_o,
    output logic [CNT_W-1:0]       cycle_cnt_o,
    output logic [CNT_W-1:0]       instret_o,
    output logic [2:0]             state_o
);

    if (NPORTS < 1 || NPORTS > 4) begin : g_err_nports
        $error("riscv_test_monitor: NPORTS must be in 1..4");
    end
    if (NUM_REG == 0 || DONE_REG == 0 || PASS_REG == 0 ||
        NUM_REG == DONE_REG || NUM_REG == PASS_REG || DONE_REG == PASS_REG ||
        NUM_REG > 31 || DONE_REG > 31 || PASS_REG > 31) begin : g_err_regs
        $error("riscv_test_monitor: NUM_REG/DONE_REG/PASS_REG must be distinct, nonzero, < 32");
    end

    localparam logic [4:0]       NumIdx      = 5'(NUM_REG);
    localparam logic [4:0]       DoneIdx     = 5'(DONE_REG);
    localparam logic [4:0]       PassIdx     = 5'(PASS_REG);
    localparam bit               TimeoutEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TimeoutLast = TimeoutEn ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  num_q, num_d, pass_q, pass_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;
    logic             done_q, pass_st_q, fail_q, timeout_q;

    logic [XLEN-1:0]  num_snoop, pass_snoop;
    logic             done_wr;
    logic [CNT_W:0]   ret_sum, ins_sum;

    // Snoop all ports; iterating upward lets the highest port index win on collisions
    always_comb begin
        num_snoop  = num_q;
        pass_snoop = pass_q;
        done_wr    = 1'b0;
        ret_sum    = '0;
        for (int p = 0; p < int'(NPORTS); p++) begin
            if (rf_we_i[p] && rf_waddr_i[5*p +: 5] != 5'd0) begin
                if (rf_waddr_i[5*p +: 5] == NumIdx)  num_snoop  = rf_wdata_i[XLEN*p +: XLEN];
                if (rf_waddr_i[5*p +: 5] == PassIdx) pass_snoop = rf_wdata_i[XLEN*p +: XLEN];
                if (rf_waddr_i[5*p +: 5] == DoneIdx &&
                    rf_wdata_i[XLEN*p +: XLEN] == XLEN'(1)) begin
                    done_wr = 1'b1;
                end
            end
            ret_sum = ret_sum + {{CNT_W{1'b0}}, retire_i[p]};
        end
        ins_sum = {1'b0, ins_q} + ret_sum;
    end

    // Next-state, shadow and counter update; clear overrides everything
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        pass_d  = pass_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    num_d   = '0;
                    pass_d  = '0;
                    cyc_d   = '0;
                    ins_d   = '0;
                end
            end
            StRun: begin
                num_d  = num_snoop;
                pass_d = pass_snoop;
                cyc_d  = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
                ins_d  = ins_sum[CNT_W] ? '1 : ins_sum[CNT_W-1:0];
                // A done write beats a timeout landing on the same cycle
                if (done_wr) begin
                    state_d = (pass_snoop == XLEN'(1)) ? StPass : StFail;
                end else if (TimeoutEn && cyc_q == TimeoutLast) begin
                    state_d = StTimeout;
                end
            end
            StPass, StFail, StTimeout: ;
            default: state_d = StIdle;
        endcase
        if (clear_i) begin
            state_d = StIdle;
            num_d   = '0;
            pass_d  = '0;
            cyc_d   = '0;
            ins_d   = '0;
        end
    end

    // State, shadow, counter and registered status flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            num_q     <= '0;
            pass_q    <= '0;
            cyc_q     <= '0;
            ins_q     <= '0;
            done_q    <= 1'b0;
            pass_st_q <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            pass_q    <= pass_d;
            cyc_q     <= cyc_d;
            ins_q     <= ins_d;
            done_q    <= state_d inside {StPass, StFail, StTimeout};
            pass_st_q <= (state_d == StPass);
            fail_q    <= state_d inside {StFail, StTimeout};
            timeout_q <= (state_d == StTimeout);
        end
    end

    assign done_o      = done_q;
    assign pass_o      = pass_st_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign testnum_o   = num_q;
    assign cycle_cnt_o = cyc_q;
    assign instret_o   = ins_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Testbench for riscv_test_monitor: directed scenarios plus randomized traffic,
// all checked against a register-level reference model of the test protocol.
module tb_riscv_test_monitor;

    localparam int XLEN = 64;
    localparam int NP   = 2;
    localparam int TO   = 50;
    localparam int CW   = 32;

    logic              clk = 1'b0;
    logic              rst, start_i, clear_i;
    logic [NP-1:0]     rf_we_i, retire_i;
    logic [5*NP-1:0]   rf_waddr_i;
    logic [XLEN*NP-1:0] rf_wdata_i;
    logic              done_o, pass_o, fail_o, timeout_o;
    logic [XLEN-1:0]   testnum_o;
    logic [CW-1:0]     cycle_cnt_o, instret_o;
    logic [2:0]        state_o;

    int total = 0;
    int bad   = 0;

    riscv_test_monitor #(
        .XLEN(XLEN), .NPORTS(NP), .NUM_REG(3), .DONE_REG(26), .PASS_REG(27),
        .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
        .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i),
        .retire_i(retire_i), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
        .timeout_o(timeout_o), .testnum_o(testnum_o), .cycle_cnt_o(cycle_cnt_o),
        .instret_o(instret_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 run, 2 pass, 3 fail, 4 timeout
    int          m_st;
    logic [63:0] m_num, m_pass, m_cyc, m_ins;

    wire [134:0] obs = {done_o, pass_o, fail_o, timeout_o, state_o, testnum_o,
                        cycle_cnt_o, instret_o};

    function automatic logic [134:0] exp_vec();
        logic [2:0] s;
        s = 3'(m_st);
        return {m_st >= 2, m_st == 2, m_st == 3 || m_st == 4, m_st == 4, s, m_num,
                m_cyc[31:0], m_ins[31:0]};
    endfunction

    function automatic void model_zero();
        m_num = 0; m_pass = 0; m_cyc = 0; m_ins = 0;
    endfunction

    // Apply one clock of the test protocol using the inputs currently driven
    function automatic void model_step();
        logic [63:0] nv_num, nv_pass;
        logic [4:0]  a;
        logic [63:0] d;
        bit          hit, timed;
        if (rst) begin m_st = 0; model_zero(); return; end
        if (clear_i) begin m_st = 0; model_zero(); return; end
        if (m_st == 0) begin
            if (start_i) begin m_st = 1; model_zero(); end
        end else if (m_st == 1) begin
            nv_num = m_num; nv_pass = m_pass; hit = 0;
            for (int p = 0; p < NP; p++) begin
                a = rf_waddr_i[5*p +: 5];
                d = rf_wdata_i[64*p +: 64];
                if (rf_we_i[p] && a != 0) begin
                    if (a == 3)  nv_num = d;
                    if (a == 27) nv_pass = d;
                    if (a == 26 && d == 64'd1) hit = 1;
                end
            end
            timed = (m_cyc == TO - 1);
            if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
            m_ins = m_ins + 64'($countones(retire_i));
            if (m_ins > 64'hFFFF_FFFF) m_ins = 64'hFFFF_FFFF;
            m_num = nv_num; m_pass = nv_pass;
            if (hit) m_st = (nv_pass == 64'd1) ? 2 : 3;
            else if (timed) m_st = 4;
        end
    endfunction

    task automatic idle();
        rst = 0; start_i = 0; clear_i = 0; rf_we_i = '0; rf_waddr_i = '0;
        rf_wdata_i = '0; retire_i = '0;
    endtask

    task automatic wr(input int p, input int addr, input logic [63:0] data);
        logic [4:0] a5;
        a5 = addr[4:0];
        rf_we_i[p] = 1'b1;
        rf_waddr_i[5*p +: 5] = a5;
        rf_wdata_i[64*p +: 64] = data;
    endtask

    // Advance one clock and leave inputs idle for the next stimulus
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1; step();
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL reset obs=%h exp=%h", obs, exp_vec());
        end
        total++;
        if (done_o !== 1'b0 || state_o !== 3'd0) begin
            bad++; $display("FAIL reset_zero done=%b state=%0d exp 0/0", done_o, state_o);
        end
    endtask

    task automatic test_pass();
        start_i = 1; step();
        wr(0, 3, 64'd5); step();
        wr(0, 27, 64'd1); step();
        wr(0, 26, 64'd1); step();
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL pass_end obs=%h exp=%h", obs, exp_vec());
        end
        total++;
        if (done_o !== 1'b1 || pass_o !== 1'b1 || testnum_o !== 64'd5) begin
            bad++; $display("FAIL pass_known done=%b pass=%b num=%0d exp 1/1/5",
                            done_o, pass_o, testnum_o);
        end
        for (int i = 0; i < 100; i++) begin
            start_i = ($urandom % 4 == 0);
            retire_i = NP'($urandom);
            if ($urandom % 3 == 0) wr(1, 26, 64'd1);
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL pass_hold[%0d] obs=%h exp=%h", i, obs, exp_vec());
            end
        end
        clear_i = 1; start_i = 1; step();
        total++;
        if (obs !== exp_vec() || done_o !== 1'b0) begin
            bad++; $display("FAIL clear_in_pass obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_fail();
        start_i = 1; step();
        wr(0, 3, 64'd7); step();
        wr(0, 27, 64'd0); step();
        wr(0, 26, 64'd1); step();
        total++;
        if (fail_o !== 1'b1 || pass_o !== 1'b0 || timeout_o !== 1'b0 ||
            testnum_o !== 64'd7 || cycle_cnt_o !== 32'd3) begin
            bad++; $display("FAIL fail_known f=%b p=%b t=%b num=%0d cyc=%0d exp 1/0/0/7/3",
                            fail_o, pass_o, timeout_o, testnum_o, cycle_cnt_o);
        end
        repeat (5) begin retire_i = '1; step(); end
        total++;
        if (obs !== exp_vec() || cycle_cnt_o !== 32'd3) begin
            bad++; $display("FAIL fail_frozen obs=%h exp=%h", obs, exp_vec());
        end
        clear_i = 1; step();
    endtask

    task automatic test_timeout();
        start_i = 1; step();
        repeat (TO) step();
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL timeout obs=%h exp=%h", obs, exp_vec());
        end
        total++;
        if (done_o !== 1'b1 || fail_o !== 1'b1 || timeout_o !== 1'b1 ||
            cycle_cnt_o !== 32'd50) begin
            bad++; $display("FAIL timeout_known d=%b f=%b t=%b cyc=%0d exp 1/1/1/50",
                            done_o, fail_o, timeout_o, cycle_cnt_o);
        end
        clear_i = 1; step();
        start_i = 1; step();
        repeat (TO - 1) step();
        wr(0, 27, 64'd1); wr(1, 26, 64'd1); step();
        total++;
        if (obs !== exp_vec() || pass_o !== 1'b1 || timeout_o !== 1'b0) begin
            bad++; $display("FAIL done_beats_timeout obs=%h exp=%h", obs, exp_vec());
        end
        clear_i = 1; step();
    endtask

    task automatic test_multiport();
        start_i = 1; step();
        wr(0, 3, 64'd2); wr(1, 3, 64'd9); step();
        wr(0, 0, 64'd123); step();
        total++;
        if (testnum_o !== 64'd9 || obs !== exp_vec()) begin
            bad++; $display("FAIL port_priority num=%0d exp 9", testnum_o);
        end
        wr(0, 27, 64'd1); wr(1, 26, 64'd1); step();
        total++;
        if (pass_o !== 1'b1 || obs !== exp_vec()) begin
            bad++; $display("FAIL same_cycle_pass obs=%h exp=%h", obs, exp_vec());
        end
        clear_i = 1; step();
    endtask

    task automatic test_instret();
        start_i = 1; step();
        for (int i = 0; i < 10; i++) begin
            retire_i = 2'b11;
            if (i == 4) wr(1, 26, 64'd2);
            step();
        end
        total++;
        if (instret_o !== 32'd20 || state_o !== 3'd1 || done_o !== 1'b0) begin
            bad++; $display("FAIL instret ins=%0d state=%0d done=%b exp 20/1/0",
                            instret_o, state_o, done_o);
        end
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL instret_model obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_rst_mid();
        wr(0, 3, 64'd44); retire_i = 2'b01; step();
        rst = 1; step();
        total++;
        if (obs !== 135'd0 || obs !== exp_vec()) begin
            bad++; $display("FAIL rst_mid obs=%h exp=0", obs);
        end
    endtask

    task automatic test_random();
        int addrs[4] = '{3, 26, 27, 0};
        for (int it = 0; it < 20; it++) begin
            clear_i = 1; step();
            start_i = 1; step();
            for (int c = 0; c < 60; c++) begin
                for (int p = 0; p < NP; p++) begin
                    if ($urandom % 3 == 0) begin
                        int a;
                        logic [63:0] d;
                        a = ($urandom % 5 == 4) ? int'($urandom % 32) : addrs[$urandom % 4];
                        d = ($urandom % 3 == 0) ? 64'd1 :
                            ($urandom % 2 == 0) ? 64'd0 : {$urandom, $urandom};
                        wr(p, a, d);
                    end
                end
                retire_i = NP'($urandom);
                start_i  = ($urandom % 8 == 0);
                clear_i  = ($urandom % 50 == 0);
                step();
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL random[%0d.%0d] obs=%h exp=%h", it, c, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        m_st = 0; model_zero();
        idle();
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_multiport();
        test_instret();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
